// File: rtl/mastermind_game.sv
// mastermind_game -- board-level Mastermind controller.
//
// The player edits a 4-peg guess (colours 0..5) with the U/D/L/R buttons and
// submits it with S. Each submitted guess is scored peg-by-peg on four RGB
// LEDs, the current turn (0..7) is shown one-hot on the switch LEDs, and the
// guess (or the secret) is shown on a multiplexed 4-digit 7-segment display.
// Secrets come from a free-running 16-bit Fibonacci LFSR.
//
// Ports:
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   sw                  1 = show secret on the display, 0 = show guess
//   btnS/btnR/btnL/btnU/btnD  debounced, synchronous push-buttons
//   seg[7:0]            active-low segments {dp,g,f,e,d,c,b,a}
//   an[3:0]             active-low digit enables, an[3] = peg 0
//   rgb0_out..rgb3_out  {R,G,B} feedback for pegs 0..3
//   sw_led[7:0]         turn indicator (one-hot / all on = win / off = lose)
module mastermind_game #(
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          REFRESH_BITS = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sw,
  input  logic       btnS,
  input  logic       btnR,
  input  logic       btnL,
  input  logic       btnU,
  input  logic       btnD,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [2:0] rgb0_out,
  output logic [2:0] rgb1_out,
  output logic [2:0] rgb2_out,
  output logic [2:0] rgb3_out,
  output logic [7:0] sw_led
);

  typedef enum logic [1:0] {PLAY = 2'd0, WIN = 2'd1, LOSE = 2'd2} state_t;

  localparam logic [REFRESH_BITS-1:0] REFRESH_ONE = 1;

  // Fold a raw 3-bit LFSR field (0..7) onto the colour range 0..5.
  function automatic logic [2:0] mod6(input logic [2:0] v);
    return (v >= 3'd6) ? v - 3'd6 : v;
  endfunction

  // Peg k of a secret is taken from LFSR bits [3k+2:3k].
  function automatic logic [11:0] code_from(input logic [15:0] r);
    return {mod6(r[11:9]), mod6(r[8:6]), mod6(r[5:3]), mod6(r[2:0])};
  endfunction

  // Active-low {g,f,e,d,c,b,a} glyphs for the decimal digits 0..5.
  function automatic logic [6:0] glyph(input logic [2:0] v);
    case (v)
      3'd0:    return 7'h40;
      3'd1:    return 7'h79;
      3'd2:    return 7'h24;
      3'd3:    return 7'h30;
      3'd4:    return 7'h19;
      3'd5:    return 7'h12;
      default: return 7'h7F;
    endcase
  endfunction

  state_t                  state, state_next;
  logic [15:0]             lfsr;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [4:0]              btn_prev;
  logic [3:0][2:0]         guess;
  logic [3:0][2:0]         secret;
  logic [3:0][2:0]         rgb;
  logic [1:0]              cursor;
  logic [2:0]              turn;

  // ---------------- button edges and single-action priority ----------------
  logic [4:0] btns, rise;
  logic       act_s, act_l, act_r, act_u, act_d;

  assign btns  = {btnS, btnL, btnR, btnU, btnD};
  assign rise  = btns & ~btn_prev;
  assign act_s = rise[4];
  assign act_l = rise[3] & ~rise[4];
  assign act_r = rise[2] & ~|rise[4:3];
  assign act_u = rise[1] & ~|rise[4:2];
  assign act_d = rise[0] & ~|rise[4:1];

  // ---------------- scoring ----------------
  logic [3:0]      exact, present;
  logic [3:0][2:0] score;

  for (genvar gi = 0; gi < 4; gi++) begin : g_score
    assign exact[gi]   = (guess[gi] == secret[gi]);
    assign present[gi] = (guess[gi] == secret[0]) | (guess[gi] == secret[1]) |
                         (guess[gi] == secret[2]) | (guess[gi] == secret[3]);
    assign score[gi]   = exact[gi]   ? 3'b010 :
                         present[gi] ? 3'b110 : 3'b000;
  end

  // ---------------- game state machine ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PLAY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      PLAY: begin
        if (act_s) begin
          if (&exact)            state_next = WIN;
          else if (turn == 3'd7) state_next = LOSE;
        end
      end
      WIN, LOSE: if (act_s) state_next = PLAY;
      default:   state_next = PLAY;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr        <= SEED;
      refresh_cnt <= '0;
      btn_prev    <= '0;
      guess       <= '0;
      secret      <= code_from(SEED);
      rgb         <= '0;
      cursor      <= 2'd0;
      turn        <= 3'd0;
    end else begin
      // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      refresh_cnt <= refresh_cnt + REFRESH_ONE;
      btn_prev    <= btns;
      if (state == PLAY) begin
        if (act_s) begin
          rgb <= score;
          // On a winning or final turn the counter is left alone; sw_led
          // no longer shows it.
          if (!(&exact) && turn != 3'd7) turn <= turn + 3'd1;
        end else if (act_l) begin
          cursor <= cursor - 2'd1;   // 2-bit wrap gives 0 -> 3
        end else if (act_r) begin
          cursor <= cursor + 2'd1;   // 3 -> 0
        end else if (act_u) begin
          guess[cursor] <= (guess[cursor] == 3'd5) ? 3'd0 : guess[cursor] + 3'd1;
        end else if (act_d) begin
          guess[cursor] <= (guess[cursor] == 3'd0) ? 3'd5 : guess[cursor] - 3'd1;
        end
      end else if (act_s) begin
        // New game: the secret is drawn from the LFSR value of this cycle.
        secret <= code_from(lfsr);
        guess  <= '0;
        cursor <= 2'd0;
        turn   <= 3'd0;
        rgb    <= '0;
      end
    end
  end

  assign rgb0_out = rgb[0];
  assign rgb1_out = rgb[1];
  assign rgb2_out = rgb[2];
  assign rgb3_out = rgb[3];

  always_comb begin
    sw_led = 8'h00;
    case (state)
      PLAY:    sw_led = 8'd1 << turn;
      WIN:     sw_led = 8'hFF;
      default: sw_led = 8'h00;
    endcase
  end

  // ---------------- display multiplexing ----------------
  logic [1:0] digit;
  logic [2:0] shown;

  assign digit = refresh_cnt[REFRESH_BITS-1 -: 2];
  assign an    = ~(4'b1000 >> digit);
  assign shown = (sw || state == LOSE) ? secret[digit] : guess[digit];
  assign seg   = {~(state == PLAY && cursor == digit), glyph(shown)};

endmodule

// File: tb/tb_mastermind_game.sv
// tb_mastermind_game -- self-checking bench for mastermind_game.
//
// A behavioural game model (integer pegs, explicit search for yellow
// matches, segment glyphs built from lists of lit segments) is advanced on
// every rising edge; one compare process checks every DUT output against it
// on each falling edge. Directed scenarios add hand-computed literal checks,
// then a randomized phase drives random buttons, switch and resets.
module tb_mastermind_game;

  localparam int RB = 4;   // short refresh counter so all digits are seen quickly

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw = 1'b0;
  logic       btnS = 1'b0, btnR = 1'b0, btnL = 1'b0, btnU = 1'b0, btnD = 1'b0;
  logic [7:0] seg;
  logic [3:0] an;
  logic [2:0] rgb0_out, rgb1_out, rgb2_out, rgb3_out;
  logic [7:0] sw_led;

  mastermind_game #(.SEED(16'hACE1), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btnS(btnS), .btnR(btnR), .btnL(btnL), .btnU(btnU), .btnD(btnD),
    .seg(seg), .an(an),
    .rgb0_out(rgb0_out), .rgb1_out(rgb1_out), .rgb2_out(rgb2_out), .rgb3_out(rgb3_out),
    .sw_led(sw_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // button vector order used by the stimulus: {S,L,R,U,D}
  localparam logic [4:0] B_S = 5'b10000, B_L = 5'b01000, B_R = 5'b00100,
                         B_U = 5'b00010, B_D = 5'b00001, B_0 = 5'b00000;

  // ---------------- behavioural model ----------------
  localparam int M_PLAY = 0, M_WIN = 1, M_LOSE = 2;
  int          m_guess[4], m_sec[4], m_rgb[4];
  int          m_cursor, m_turn, m_state, m_cnt;
  logic [15:0] m_lfsr;
  logic [4:0]  m_prev;

  task automatic new_secret(input logic [15:0] r);
    for (int k = 0; k < 4; k++) m_sec[k] = int'((r >> (3 * k)) & 16'h7) % 6;
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    new_secret(m_lfsr);
    for (int k = 0; k < 4; k++) begin m_guess[k] = 0; m_rgb[k] = 0; end
    m_cursor = 0; m_turn = 0; m_state = M_PLAY; m_cnt = 0; m_prev = '0;
  endtask

  task automatic model_step();
    logic [4:0] b, r;
    int hits;
    b = {btnS, btnL, btnR, btnU, btnD};
    r = b & ~m_prev;
    m_prev = b;
    if (r[4]) begin
      if (m_state == M_PLAY) begin
        hits = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_guess[i] == m_sec[i]) begin
            m_rgb[i] = 2; hits++;
          end else begin
            m_rgb[i] = 0;
            for (int j = 0; j < 4; j++) if (m_guess[i] == m_sec[j]) m_rgb[i] = 6;
          end
        end
        if (hits == 4)         m_state = M_WIN;
        else if (m_turn == 7)  m_state = M_LOSE;
        else                   m_turn++;
      end else begin
        new_secret(m_lfsr);
        for (int k = 0; k < 4; k++) begin m_guess[k] = 0; m_rgb[k] = 0; end
        m_cursor = 0; m_turn = 0; m_state = M_PLAY;
      end
    end else if (m_state == M_PLAY) begin
      if (r[3])      m_cursor = (m_cursor + 3) % 4;
      else if (r[2]) m_cursor = (m_cursor + 1) % 4;
      else if (r[1]) m_guess[m_cursor] = (m_guess[m_cursor] + 1) % 6;
      else if (r[0]) m_guess[m_cursor] = (m_guess[m_cursor] + 5) % 6;
    end
    m_cnt = (m_cnt + 1) % (1 << RB);
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Active-low glyph assembled from the names of the lit segments.
  function automatic logic [6:0] glyph_of(input int v);
    string lit;
    logic [6:0] g;
    g = 7'h7F;
    case (v)
      0: lit = "abcdef";
      1: lit = "bc";
      2: lit = "abdeg";
      3: lit = "abcdg";
      4: lit = "bcfg";
      default: lit = "acdfg";
    endcase
    for (int i = 0; i < lit.len(); i++) g[int'(lit[i]) - 97] = 1'b0;
    return g;
  endfunction

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      int d, v, e_led;
      logic [7:0] e_seg;
      d = m_cnt >> (RB - 2);
      v = (sw || m_state == M_LOSE) ? m_sec[d] : m_guess[d];
      e_seg = {~(m_state == M_PLAY && m_cursor == d), glyph_of(v)};
      e_led = (m_state == M_PLAY) ? (1 << m_turn) : (m_state == M_WIN) ? 8'hFF : 0;
      chk("seg", int'(seg), int'(e_seg));
      chk("an", int'(an), int'(4'hF & ~(4'b1000 >> d)));
      chk("rgb0", int'(rgb0_out), m_rgb[0]);
      chk("rgb1", int'(rgb1_out), m_rgb[1]);
      chk("rgb2", int'(rgb2_out), m_rgb[2]);
      chk("rgb3", int'(rgb3_out), m_rgb[3]);
      chk("sw_led", int'(sw_led), e_led);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive buttons, let one rising edge sample them, return 1 time unit later.
  task automatic cyc(input logic [4:0] b);
    {btnS, btnL, btnR, btnU, btnD} = b;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] b);
    cyc(b);
    cyc(B_0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(B_0);
    cyc(B_0);
    rst_n = 1'b1;
  endtask

  logic [6:0] glyph_lit[6];
  logic [3:0] an_seq[4];
  int         exp_code[4];

  task automatic chk_display_code();
    for (int c = 0; c < (1 << RB); c++) begin
      for (int i = 0; i < 4; i++)
        if (an[3 - i] == 1'b0) chk("disp_secret", int'(seg[6:0]), int'(glyph_lit[exp_code[i]]));
      cyc(B_0);
    end
  endtask

  task automatic chk_rgbs(input int e0, input int e1, input int e2, input int e3);
    chk("lit_rgb0", int'(rgb0_out), e0);
    chk("lit_rgb1", int'(rgb1_out), e1);
    chk("lit_rgb2", int'(rgb2_out), e2);
    chk("lit_rgb3", int'(rgb3_out), e3);
  endtask

  initial begin
    int guard;
    glyph_lit = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
    an_seq    = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    exp_code  = '{1, 4, 3, 0};

    // ---- reset state ----
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    cyc(B_0);
    chk_rgbs(0, 0, 0, 0);
    chk("reset_sw_led", int'(sw_led), 8'h01);
    chk("reset_an", int'(an), 4'b0111);
    chk("reset_seg", int'(seg), 8'h40);
    for (int k = 0; k < 4; k++) chk("model_seed_secret", m_sec[k], exp_code[k]);
    rst_n = 1'b1;

    // ---- idle: digit scan ----
    for (int d = 0; d < 4; d++) begin
      chk("an_scan", int'(an), int'(an_seq[d]));
      for (int c = 0; c < (1 << (RB - 2)); c++) cyc(B_0);
    end
    $display("scan: digit enables cycled");

    // ---- U pulse, then S held two cycles ----
    cyc(B_U);
    cyc(B_S);
    cyc(B_S);
    cyc(B_0);
    chk_rgbs(2, 6, 6, 2);
    chk("one_submit_sw_led", int'(sw_led), 8'h02);
    $display("guess 1000: rgb=%0h %0h %0h %0h sw_led=%0h", rgb0_out, rgb1_out, rgb2_out, rgb3_out, sw_led);

    // ---- enter 1,4,3,0 and win ----
    press(B_R); press(B_D); press(B_D);
    press(B_R); press(B_U); press(B_U); press(B_U);
    press(B_S);
    chk_rgbs(2, 2, 2, 2);
    chk("win_sw_led", int'(sw_led), 8'hFF);
    press(B_U); press(B_L);
    chk("win_no_dp", int'(seg[7]), 1);
    chk("win_hold_sw_led", int'(sw_led), 8'hFF);
    $display("win: sw_led=%0h", sw_led);

    // ---- 5,5,5,5 eight times -> LOSE ----
    do_reset();
    for (int k = 0; k < 4; k++) begin press(B_D); press(B_R); end
    for (int t = 0; t < 8; t++) begin
      chk("walk_sw_led", int'(sw_led), 1 << t);
      press(B_S);
      $display("submit %0d: sw_led=%0h", t, sw_led);
    end
    chk("lose_sw_led", int'(sw_led), 8'h00);
    chk_rgbs(0, 0, 0, 0);
    chk_display_code();
    press(B_S);
    chk("newgame_sw_led", int'(sw_led), 8'h01);
    chk_rgbs(0, 0, 0, 0);
    $display("new game: sw_led=%0h", sw_led);

    // ---- U and L together: only the cursor moves ----
    press(B_U | B_L);
    guard = 0;
    while (an != 4'b1110 && guard < 2 * (1 << RB)) begin cyc(B_0); guard++; end
    chk("ul_cursor_digit3", int'(seg), 8'h40);
    sw = 1'b1;
    for (int c = 0; c < (1 << RB); c++) cyc(B_0);
    sw = 1'b0;
    $display("U+L: cursor at digit 3, guess unchanged");

    // ---- reset mid-game after three turns ----
    do_reset();
    press(B_U);
    press(B_S); press(B_S); press(B_S);
    chk("three_turns_sw_led", int'(sw_led), 8'h08);
    rst_n = 1'b0;
    #1;
    chk_rgbs(0, 0, 0, 0);
    chk("async_sw_led", int'(sw_led), 8'h01);
    chk("async_an", int'(an), 4'b0111);
    chk("async_seg", int'(seg), 8'h40);
    cyc(B_0);
    rst_n = 1'b1;
    $display("mid-game reset: sw_led=%0h an=%0h seg=%0h", sw_led, an, seg);

    // ---- randomized phase ----
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] b;
      for (int k = 0; k < 5; k++) b[k] = ($urandom_range(0, 2) == 0);
      sw = ($urandom_range(0, 7) == 0);
      if (rst_n == 1'b0)                       rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0)    rst_n = 1'b0;
      cyc(b);
    end
    $display("random phase: 3000 cycles");

    cyc(B_0);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
